mux_sel_sched: RTL and testbench
================================

MUX_SEL_SCHED -- requirements
Module: mux_sel_sched

Interface
REQ-001 The module SHALL have parameter NUM_IN, default 5: number of candidate vectors selectable by the downstream 5-to-1 mux.
REQ-002 The module SHALL have parameter SEL_WIDTH, default 3: width of the select index, with 2**SEL_WIDTH >= NUM_IN.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port mask_in, input, NUM_IN bits: bit i set means candidate i is non-zero and must be issued.
REQ-006 The module SHALL have port mask_valid, input, 1 bit: mask_in is valid this cycle.
REQ-007 The module SHALL have port mask_ready, output, 1 bit: the block accepts mask_in this cycle.
REQ-008 The module SHALL have port sel_out, output, SEL_WIDTH bits: candidate index driven to the mux sel.
REQ-009 The module SHALL have port val_out, output, 1 bit: driven to the mux val; 0 forces the mux output to zero.
REQ-010 The module SHALL have port last_out, output, 1 bit: final beat of the current mask.
REQ-011 The module SHALL have port out_valid, output, 1 bit: the beat on sel_out/val_out/last_out is valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts the beat this cycle.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the FSM is in RUN.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN, and SHALL hold a NUM_IN-bit register pending.
REQ-015 A mask transfer SHALL occur on a rising edge where mask_valid && mask_ready; that edge loads pending <= mask_in and sets the state to RUN.
REQ-016 mask_ready SHALL be 1 in IDLE and in RUN when out_valid && out_ready && last_out; it SHALL be 0 otherwise, giving back-to-back masks with no bubble.
REQ-017 out_valid SHALL be 1 exactly when the state is RUN, so the first beat is valid in the cycle after the mask transfer (latency 1).
REQ-018 In RUN with pending != 0, sel_out SHALL equal the index of the lowest set bit of pending, and val_out SHALL be 1.
REQ-019 In RUN with pending != 0, last_out SHALL be 1 iff pending has exactly one set bit.
REQ-020 In RUN with pending == 0 (an all-zero mask was accepted), the block SHALL emit exactly one beat with sel_out=0, val_out=0 and last_out=1.
REQ-021 A beat transfer SHALL occur on a rising edge where out_valid && out_ready; that edge clears the lowest set bit of pending.
REQ-022 If the transferred beat has last_out=1 and no new mask is transferred on the same edge, the state SHALL return to IDLE.
REQ-023 If a new mask is transferred on the same edge as a last-beat transfer, pending SHALL load mask_in and the state SHALL remain RUN.
REQ-024 While out_valid=1 and out_ready=0, sel_out, val_out, last_out and pending SHALL hold unchanged.
REQ-025 In IDLE, sel_out, val_out and last_out SHALL be 0.
REQ-026 mask_in bits at index >= NUM_IN SHALL NOT exist; sel_out SHALL never exceed NUM_IN-1.
REQ-027 A mask with k set bits (k>=1) SHALL produce exactly k beats in ascending index order; a zero mask SHALL produce exactly 1 beat.
REQ-028 sel_out, val_out, last_out, out_valid and busy SHALL be functions of registered state only, with no combinational path from any input.
REQ-029 mask_ready SHALL have a combinational path only from out_ready.

Reset
REQ-030 While rst_n=0 at a rising edge, the state SHALL be set to IDLE and pending SHALL be set to 0.
REQ-031 From the first edge with rst_n=0, out_valid, busy, sel_out, val_out and last_out SHALL be 0, and mask_ready SHALL be 0 while rst_n=0.
REQ-032 A reset asserted in RUN SHALL discard the remaining beats, and no beat SHALL be emitted after reset until a new mask transfer.

Verification
REQ-033 Send mask 5'b10110 with out_ready=1 -> beats (sel,val,last) = (1,1,0), (2,1,0), (4,1,1) on three consecutive cycles, starting the cycle after acceptance.
REQ-034 Send mask 5'b00000 -> single beat (0,0,1), then return to IDLE with mask_ready=1.
REQ-035 Send mask 5'b11111 with out_ready toggling 1,0,1,0,... -> sel sequence 0,1,2,3,4 with each value held during stall cycles, and last_out only on sel=4.
REQ-036 Hold mask_valid=1 with mask 5'b00001 then 5'b10000 back-to-back -> beats (0,1,1), (4,1,1) on consecutive cycles, mask_ready=1 on the last-beat cycle, and busy never drops.
REQ-037 Send mask 5'b01110, then assert rst_n=0 after the first beat -> out_valid=0 from the reset edge, and no further beats until a new mask is sent.
REQ-038 A random-mask run against a scoreboard -> beat count = max(popcount,1), ascending sel order, and exactly one last_out per mask.

Source files
------------

// File: rtl/mux_sel_sched.sv
// Select scheduler for a downstream N-to-1 mux: walks the accepted mask from lowest to
// highest set bit and emits one (sel, val, last) beat per candidate.
//
// state | meaning
// IDLE  | no mask held, ready to accept one
// RUN   | issuing beats for the mask held in pending_q
module mux_sel_sched #(
    parameter int NUM_IN    = 5,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IN-1:0]    mask_in,
    input  logic                 mask_valid,
    output logic                 mask_ready,
    output logic [SEL_WIDTH-1:0] sel_out,
    output logic                 val_out,
    output logic                 last_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_IN-1:0]   pending_q, pending_d;
    logic                in_rst_q;
    logic [NUM_IN-1:0]   pending_clr;
    logic [SEL_WIDTH-1:0] lo_idx;
    logic                single;
    logic                run;
    logic                beat_xfer;
    logic                mask_xfer;

    // Registered reset flag keeps mask_ready low during reset without a path from rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            in_rst_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            in_rst_q  <= 1'b0;
        end
    end

    always_comb begin
        lo_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lo_idx = SEL_WIDTH'(i);
            end
        end
    end

    // An empty pending also counts as single: the zero mask gets exactly one last beat.
    assign pending_clr = pending_q & (pending_q - NUM_IN'(1));
    assign single      = (pending_clr == '0);
    assign run         = (state_q == RUN);

    assign out_valid  = run;
    assign busy       = run;
    assign val_out    = run && (pending_q != '0);
    assign last_out   = run && single;
    assign sel_out    = run ? lo_idx : '0;
    assign mask_ready = !in_rst_q && (!run || (out_ready && single));

    assign beat_xfer = run && out_ready;
    assign mask_xfer = mask_valid && mask_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (beat_xfer) begin
            pending_d = pending_clr;
            if (single) begin
                state_d = IDLE;
            end
        end
        if (mask_xfer) begin
            pending_d = mask_in;
            state_d   = RUN;
        end
    end

endmodule

// File: tb/tb_mux_sel_sched.sv
// Directed and randomized checks of mux_sel_sched beat ordering, handshakes and reset.
module tb_mux_sel_sched;

    logic       clk;
    logic       rst_n;
    logic [4:0] mask_in;
    logic       mask_valid;
    logic       mask_ready;
    logic [2:0] sel_out;
    logic       val_out;
    logic       last_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int tests;
    int fails;

    mux_sel_sched #(.NUM_IN(5), .SEL_WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mask_in    (mask_in),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .sel_out    (sel_out),
        .val_out    (val_out),
        .last_out   (last_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view: {out_valid, busy, mask_ready, val, last, sel[2:0]}
    function automatic logic [7:0] ex(input logic ov, input logic bz, input logic mr,
                                      input logic v, input logic l, input logic [2:0] s);
        return {ov, bz, mr, v, l, s};
    endfunction

    task automatic chk(input string tag, input logic [7:0] expv);
        logic [7:0] obs;
        obs = {out_valid, busy, mask_ready, val_out, last_out, sel_out};
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b (ov,busy,mrdy,val,last,sel)", tag, obs, expv);
        end
    endtask

    initial begin
        logic [2:0] exp_sel [$];
        logic [4:0] m;
        int         n;
        int         j;
        int         cyc;
        logic       lst;

        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        mask_in    = '0;
        mask_valid = 1'b0;
        out_ready  = 1'b0;

        step();
        step();
        chk("reset", ex(0, 0, 0, 0, 0, 3'd0));
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", ex(0, 0, 1, 0, 0, 3'd0));

        // Mask 10110, free-flowing output
        mask_in = 5'b10110; mask_valid = 1'b1; out_ready = 1'b1;
        step();
        mask_valid = 1'b0;
        chk("m10110_b0", ex(1, 1, 0, 1, 0, 3'd1));
        step();
        chk("m10110_b1", ex(1, 1, 0, 1, 0, 3'd2));
        step();
        chk("m10110_b2", ex(1, 1, 1, 1, 1, 3'd4));
        step();
        chk("m10110_idle", ex(0, 0, 1, 0, 0, 3'd0));

        // Zero mask gives one empty last beat
        mask_in = 5'b00000; mask_valid = 1'b1;
        step();
        mask_valid = 1'b0;
        chk("zero_beat", ex(1, 1, 1, 0, 1, 3'd0));
        step();
        chk("zero_idle", ex(0, 0, 1, 0, 0, 3'd0));

        // Mask 11111 with a stall cycle on every beat
        mask_in = 5'b11111; mask_valid = 1'b1;
        step();
        mask_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("full_b%0d", k), ex(1, 1, k == 4, 1, k == 4, 3'(k)));
            out_ready = 1'b0;
            #1;
            chk($sformatf("full_hold%0d", k), ex(1, 1, 0, 1, k == 4, 3'(k)));
            step();
            chk($sformatf("full_stall%0d", k), ex(1, 1, 0, 1, k == 4, 3'(k)));
            out_ready = 1'b1;
            step();
        end
        chk("full_idle", ex(0, 0, 1, 0, 0, 3'd0));

        // Back-to-back single-bit masks
        mask_in = 5'b00001; mask_valid = 1'b1;
        step();
        chk("b2b_first", ex(1, 1, 1, 1, 1, 3'd0));
        mask_in = 5'b10000;
        step();
        mask_valid = 1'b0;
        chk("b2b_second", ex(1, 1, 1, 1, 1, 3'd4));
        step();
        chk("b2b_idle", ex(0, 0, 1, 0, 0, 3'd0));

        // Reset in the middle of a mask
        mask_in = 5'b01110; mask_valid = 1'b1;
        step();
        mask_valid = 1'b0;
        chk("rst_mid_b0", ex(1, 1, 0, 1, 0, 3'd1));
        step();
        chk("rst_mid_b1", ex(1, 1, 0, 1, 0, 3'd2));
        rst_n = 1'b0;
        step();
        chk("rst_mid_inreset", ex(0, 0, 0, 0, 0, 3'd0));
        rst_n = 1'b1;
        step();
        chk("rst_mid_release", ex(0, 0, 1, 0, 0, 3'd0));
        step();
        step();
        chk("rst_mid_quiet", ex(0, 0, 1, 0, 0, 3'd0));
        mask_in = 5'b00100; mask_valid = 1'b1;
        step();
        mask_valid = 1'b0;
        chk("rst_mid_newmask", ex(1, 1, 1, 1, 1, 3'd2));
        step();
        chk("rst_mid_idle", ex(0, 0, 1, 0, 0, 3'd0));

        // Random masks against a scoreboard of expected ascending indices
        for (int t = 0; t < 24; t++) begin
            m = 5'($urandom_range(0, 31));
            exp_sel.delete();
            for (int b = 0; b < 5; b++) begin
                if (m[b]) exp_sel.push_back(3'(b));
            end
            n = (exp_sel.size() == 0) ? 1 : exp_sel.size();
            out_ready  = 1'b0;
            mask_in    = m;
            mask_valid = 1'b1;
            step();
            mask_valid = 1'b0;
            j   = 0;
            cyc = 0;
            while (j < n && cyc < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                lst = (j == n - 1);
                if (exp_sel.size() == 0)
                    chk($sformatf("rand%0d_beat%0d", t, j), ex(1, 1, out_ready, 0, 1, 3'd0));
                else
                    chk($sformatf("rand%0d_beat%0d", t, j),
                        ex(1, 1, lst && out_ready, 1, lst, exp_sel[j]));
                if (out_ready) j++;
                step();
                cyc++;
            end
            tests++;
            assert (j == n)
            else begin
                fails++;
                $error("FAIL rand%0d_count observed=%0d expected=%0d", t, j, n);
            end
            out_ready = 1'b0;
            #1;
            chk($sformatf("rand%0d_idle", t), ex(0, 0, 1, 0, 0, 3'd0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
